adder_checker: RTL and testbench
================================

ADDER_CHECKER -- requirements
Module: adder_checker

Interface
REQ-001 Parameter BITS, default 16, width of expected and actual result words.
REQ-002 Parameter DEPTH, default 8, expected-result FIFO entries; power of two, >= 2.
REQ-003 Parameter TIMEOUT, default 64, max cycles without progress while results are outstanding.
REQ-004 Parameter STOP_ON_FAIL, default 1; 1 = FAIL on first mismatch, 0 = keep comparing and counting.
REQ-005 One clock; reset is synchronous and active-high.
REQ-006 clk  input  1  rising-edge clock.
REQ-007 reset  input  1  synchronous, active-high reset.
REQ-008 exp_valid  input  1  push exp_data into the expected FIFO.
REQ-009 exp_data  input  BITS  expected adder result.
REQ-010 exp_ready  output  1  FIFO not full.
REQ-011 stim_done  input  1  level; stimulus side has pushed all expected words.
REQ-012 act_valid  input  1  adder valid_out.
REQ-013 act_data  input  BITS  adder o.
REQ-014 pass  output  1  sticky; test passed.
REQ-015 fail  output  1  sticky; test failed.
REQ-016 fail_cause  output  2  0 none, 1 mismatch, 2 unexpected output / overflow, 3 timeout.
REQ-017 match_count  output  16  compares that matched.
REQ-018 mismatch_count  output  16  compares that mismatched.
REQ-019 first_exp, first_act  output  BITS each  operands of the first mismatch.

Function
REQ-020 FSM states: IDLE, RUN, PASS, FAIL; PASS and FAIL are terminal until reset.
REQ-021 IDLE->RUN on the first accepted push (exp_valid & exp_ready).
REQ-022 Push accepted when exp_valid & exp_ready in IDLE or RUN; ignored in PASS/FAIL.
REQ-023 exp_valid while full: word dropped; next state FAIL, cause 2.
REQ-024 Compare on act_valid in RUN: head popped, act_data == head -> match_count+1, else mismatch_count+1.
REQ-025 Compare is registered: counters, first_* and state update on the clock edge of the act_valid cycle; visible next cycle.
REQ-026 First mismatch captures first_exp/first_act; later mismatches do not overwrite them.
REQ-027 Mismatch with STOP_ON_FAIL=1: next state FAIL, cause 1. With STOP_ON_FAIL=0: stay RUN; at completion go FAIL, cause 1, if mismatch_count != 0.
REQ-028 act_valid with FIFO empty: FAIL, cause 2, even if a push occurs the same cycle (no bypass).
REQ-029 act_valid in IDLE: FAIL, cause 2.
REQ-030 Simultaneous push and pop on a non-empty FIFO: occupancy unchanged; both take effect.
REQ-031 Pointers wrap modulo DEPTH; full/empty use an extra pointer bit.
REQ-032 Completion: RUN & stim_done & FIFO empty & no act_valid this cycle -> PASS (or FAIL per REQ-027).
REQ-033 Timeout counter clears on any accepted push or act_valid and increments otherwise while RUN & FIFO non-empty; reaching TIMEOUT -> FAIL, cause 3.
REQ-034 Counters saturate at 0xFFFF.
REQ-035 Priority in one cycle: cause 2 > cause 1 > cause 3 > completion.

Reset
REQ-036 reset high at a rising edge: state IDLE, FIFO empty, exp_ready=1, pass=0, fail=0, fail_cause=0, counters=0, first_*=0, timeout counter=0.
REQ-037 Reset mid-operation discards FIFO contents and sticky results in the same edge; inputs during reset are ignored.

Verification
REQ-038 Push 0x11f5, 0x57b1, 0xb4bf, 0x15dc; act_data the same values one per cycle; stim_done=1 -> pass=1, match_count=4, mismatch_count=0.
REQ-039 Same pushes; second act_data = 0x57b0, STOP_ON_FAIL=1 -> fail=1, fail_cause=1, first_exp=0x57b1, first_act=0x57b0, match_count=1.
REQ-040 STOP_ON_FAIL=0, two of four mismatching, stim_done=1 -> fail=1, fail_cause=1, match_count=2, mismatch_count=2, first_* = first bad pair.
REQ-041 Push 9 words with no act_valid, DEPTH=8 -> exp_ready=0 after 8th; 9th push -> fail_cause=2.
REQ-042 Push 0x11f5, never assert act_valid -> fail_cause=3 exactly TIMEOUT cycles after the push.
REQ-043 act_valid before any push -> fail_cause=2; reset asserted for one cycle -> all outputs return to REQ-036 values; rerun REQ-038 passes.

Source files
------------

// File: rtl/adder_checker.sv
// -----------------------------------------------------------------------------
// adder_checker
//
// Scoreboard for an adder under test. The stimulus side pushes expected results
// into a small FIFO. The adder's results arrive on act_valid/act_data and are
// compared in order against the head of that FIFO. The checker ends in one of
// two sticky states, pass or fail, and stays there until reset.
//
// Parameters
//   BITS         width of the expected and actual result words
//   DEPTH        number of expected-result FIFO entries (power of two, >= 2)
//   TIMEOUT      cycles allowed without progress while results are outstanding
//   STOP_ON_FAIL 1: fail on the first mismatch; 0: keep comparing, fail at end
//
// Ports
//   clk            rising-edge clock
//   reset          synchronous, active-high reset
//   exp_valid      push exp_data into the expected FIFO
//   exp_data       expected adder result
//   exp_ready      FIFO not full
//   stim_done      level: all expected words have been pushed
//   act_valid      adder output valid
//   act_data       adder output word
//   pass           sticky, test passed
//   fail           sticky, test failed
//   fail_cause     0 none, 1 mismatch, 2 unexpected output/overflow, 3 timeout
//   match_count    saturating count of matching compares
//   mismatch_count saturating count of mismatching compares
//   first_exp      expected word of the first mismatch
//   first_act      actual word of the first mismatch
// -----------------------------------------------------------------------------
module adder_checker #(
  parameter int BITS         = 16,
  parameter int DEPTH        = 8,
  parameter int TIMEOUT      = 64,
  parameter int STOP_ON_FAIL = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            exp_valid,
  input  logic [BITS-1:0] exp_data,
  output logic            exp_ready,
  input  logic            stim_done,
  input  logic            act_valid,
  input  logic [BITS-1:0] act_data,
  output logic            pass,
  output logic            fail,
  output logic [1:0]      fail_cause,
  output logic [15:0]     match_count,
  output logic [15:0]     mismatch_count,
  output logic [BITS-1:0] first_exp,
  output logic [BITS-1:0] first_act
);

  localparam int AW = $clog2(DEPTH);
  localparam int TW = $clog2(TIMEOUT + 1);

  localparam logic [1:0] CAUSE_MISMATCH   = 2'd1;
  localparam logic [1:0] CAUSE_UNEXPECTED = 2'd2;
  localparam logic [1:0] CAUSE_TIMEOUT    = 2'd3;

  typedef enum logic [1:0] {IDLE, RUN, PASS, FAIL} state_t;

  state_t          state;
  logic [BITS-1:0] mem [DEPTH];
  logic [AW:0]     wr_ptr;
  logic [AW:0]     rd_ptr;
  logic [TW-1:0]   tmo_cnt;

  logic            active;
  logic            full;
  logic            empty;
  logic            push;
  logic            overflow;
  logic            unexpected;
  logic            pop;
  logic            mismatch;
  logic            match;
  logic            stalled;
  logic            tmo_hit;
  logic            done;
  logic [BITS-1:0] head;

  // Pointers carry one extra wrap bit: equal pointers mean empty, equal
  // indices with differing wrap bits mean full.
  always_comb begin
    active     = (state == IDLE) || (state == RUN);
    empty      = (wr_ptr == rd_ptr);
    full       = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    exp_ready  = !full;
    head       = mem[rd_ptr[AW-1:0]];

    push       = exp_valid && !full && active;
    overflow   = exp_valid && full && active;
    // A result with nothing outstanding is an error even if a push lands in
    // the same cycle; the pushed word is not forwarded to the compare.
    unexpected = act_valid && ((state == IDLE) || ((state == RUN) && empty));
    pop        = act_valid && (state == RUN) && !empty;
    mismatch   = pop && (act_data != head);
    match      = pop && (act_data == head);

    stalled    = (state == RUN) && !empty && !push && !act_valid;
    tmo_hit    = stalled && (tmo_cnt == TW'(TIMEOUT - 1));
    done       = (state == RUN) && stim_done && empty && !act_valid;
  end

  // FIFO storage has no reset; validity is tracked entirely by the pointers.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr[AW-1:0]] <= exp_data;
    end
  end

  // Control FSM, FIFO pointers, counters and sticky results. Failure sources
  // are tested in priority order: unexpected/overflow, mismatch, timeout,
  // then completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      state          <= IDLE;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      tmo_cnt        <= '0;
      pass           <= 1'b0;
      fail           <= 1'b0;
      fail_cause     <= 2'd0;
      match_count    <= '0;
      mismatch_count <= '0;
      first_exp      <= '0;
      first_act      <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + (AW+1)'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + (AW+1)'(1);
      end

      if (match && (match_count != 16'hFFFF)) begin
        match_count <= match_count + 16'd1;
      end
      if (mismatch) begin
        if (mismatch_count != 16'hFFFF) begin
          mismatch_count <= mismatch_count + 16'd1;
        end
        // The count never returns to zero once non-zero (it saturates), so
        // zero reliably identifies the first mismatch.
        if (mismatch_count == 16'd0) begin
          first_exp <= head;
          first_act <= act_data;
        end
      end

      if (stalled) begin
        tmo_cnt <= tmo_cnt + TW'(1);
      end else begin
        tmo_cnt <= '0;
      end

      if (overflow || unexpected) begin
        state      <= FAIL;
        fail       <= 1'b1;
        fail_cause <= CAUSE_UNEXPECTED;
      end else if (mismatch && (STOP_ON_FAIL != 0)) begin
        state      <= FAIL;
        fail       <= 1'b1;
        fail_cause <= CAUSE_MISMATCH;
      end else if (tmo_hit) begin
        state      <= FAIL;
        fail       <= 1'b1;
        fail_cause <= CAUSE_TIMEOUT;
      end else if (done) begin
        if (mismatch_count != 16'd0) begin
          state      <= FAIL;
          fail       <= 1'b1;
          fail_cause <= CAUSE_MISMATCH;
        end else begin
          state <= PASS;
          pass  <= 1'b1;
        end
      end else if ((state == IDLE) && push) begin
        state <= RUN;
      end
    end
  end

endmodule

// File: tb/tb_adder_checker.sv
// -----------------------------------------------------------------------------
// tb_adder_checker
//
// Directed bench for adder_checker. Two instances share the stimulus: dut uses
// the default STOP_ON_FAIL=1, dut_nf uses STOP_ON_FAIL=0. Expected values are
// hand-computed constants.
// -----------------------------------------------------------------------------
module tb_adder_checker;

  localparam int TMO = 64;

  logic        clk = 1'b0;
  logic        reset;
  logic        exp_valid;
  logic [15:0] exp_data;
  logic        stim_done;
  logic        act_valid;
  logic [15:0] act_data;

  logic        exp_ready, pass, fail;
  logic [1:0]  fail_cause;
  logic [15:0] match_count, mismatch_count, first_exp, first_act;

  logic        nf_exp_ready, nf_pass, nf_fail;
  logic [1:0]  nf_fail_cause;
  logic [15:0] nf_match_count, nf_mismatch_count, nf_first_exp, nf_first_act;

  logic [15:0] words [4];

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  adder_checker #(.BITS(16), .DEPTH(8), .TIMEOUT(TMO), .STOP_ON_FAIL(1)) dut (
    .clk(clk), .reset(reset),
    .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(exp_ready),
    .stim_done(stim_done), .act_valid(act_valid), .act_data(act_data),
    .pass(pass), .fail(fail), .fail_cause(fail_cause),
    .match_count(match_count), .mismatch_count(mismatch_count),
    .first_exp(first_exp), .first_act(first_act)
  );

  adder_checker #(.BITS(16), .DEPTH(8), .TIMEOUT(TMO), .STOP_ON_FAIL(0)) dut_nf (
    .clk(clk), .reset(reset),
    .exp_valid(exp_valid), .exp_data(exp_data), .exp_ready(nf_exp_ready),
    .stim_done(stim_done), .act_valid(act_valid), .act_data(act_data),
    .pass(nf_pass), .fail(nf_fail), .fail_cause(nf_fail_cause),
    .match_count(nf_match_count), .mismatch_count(nf_mismatch_count),
    .first_exp(nf_first_exp), .first_act(nf_first_act)
  );

  // Compares one observed value against its expected value and logs misses.
  task automatic checkOutput(input string tag, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advances one clock; outputs are then stable 1 ns after the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drives one cycle of inputs and lets the following edge sample them.
  task automatic applyStimulus(input logic ev, input logic [15:0] ed,
                               input logic av, input logic [15:0] ad,
                               input logic sd);
    exp_valid = ev;
    exp_data  = ed;
    act_valid = av;
    act_data  = ad;
    stim_done = sd;
    step();
  endtask

  task automatic idleInputs();
    exp_valid = 1'b0;
    exp_data  = 16'h0;
    act_valid = 1'b0;
    act_data  = 16'h0;
    stim_done = 1'b0;
  endtask

  task automatic doReset();
    idleInputs();
    reset = 1'b1;
    step();
    reset = 1'b0;
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, ".exp_ready"}, 32'(exp_ready), 32'h1);
    checkOutput({tag, ".pass"}, 32'(pass), 32'h0);
    checkOutput({tag, ".fail"}, 32'(fail), 32'h0);
    checkOutput({tag, ".cause"}, 32'(fail_cause), 32'h0);
    checkOutput({tag, ".match"}, 32'(match_count), 32'h0);
    checkOutput({tag, ".mismatch"}, 32'(mismatch_count), 32'h0);
    checkOutput({tag, ".first_exp"}, 32'(first_exp), 32'h0);
    checkOutput({tag, ".first_act"}, 32'(first_act), 32'h0);
  endtask

  task automatic pushWords();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b1, words[i], 1'b0, 16'h0, 1'b0);
    end
  endtask

  // Four pushes, four matching results, then stim_done: expect pass.
  task automatic runPassSequence(input string tag);
    pushWords();
    for (int i = 0; i < 4; i++) begin
      applyStimulus(1'b0, 16'h0, 1'b1, words[i], 1'b0);
    end
    checkOutput({tag, ".pass_before_done"}, 32'(pass), 32'h0);
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    checkOutput({tag, ".pass"}, 32'(pass), 32'h1);
    checkOutput({tag, ".fail"}, 32'(fail), 32'h0);
    checkOutput({tag, ".match"}, 32'(match_count), 32'h4);
    checkOutput({tag, ".mismatch"}, 32'(mismatch_count), 32'h0);
    idleInputs();
  endtask

  initial begin
    words[0] = 16'h11f5;
    words[1] = 16'h57b1;
    words[2] = 16'hb4bf;
    words[3] = 16'h15dc;

    // Reset values
    doReset();
    checkReset("reset0");

    // All results match
    runPassSequence("pass");

    // Second result wrong, stop on first failure
    doReset();
    pushWords();
    applyStimulus(1'b0, 16'h0, 1'b1, 16'h11f5, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b1, 16'h57b0, 1'b0);
    checkOutput("stop.fail", 32'(fail), 32'h1);
    checkOutput("stop.cause", 32'(fail_cause), 32'h1);
    checkOutput("stop.first_exp", 32'(first_exp), 32'h57b1);
    checkOutput("stop.first_act", 32'(first_act), 32'h57b0);
    checkOutput("stop.match", 32'(match_count), 32'h1);
    checkOutput("nf.running", 32'(nf_fail), 32'h0);
    applyStimulus(1'b0, 16'h0, 1'b1, 16'hb4bf, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b1, 16'h15dd, 1'b0);
    checkOutput("stop.match_frozen", 32'(match_count), 32'h1);
    checkOutput("nf.mid_fail", 32'(nf_fail), 32'h0);
    applyStimulus(1'b0, 16'h0, 1'b0, 16'h0, 1'b1);
    checkOutput("nf.fail", 32'(nf_fail), 32'h1);
    checkOutput("nf.pass", 32'(nf_pass), 32'h0);
    checkOutput("nf.cause", 32'(nf_fail_cause), 32'h1);
    checkOutput("nf.match", 32'(nf_match_count), 32'h2);
    checkOutput("nf.mismatch", 32'(nf_mismatch_count), 32'h2);
    checkOutput("nf.first_exp", 32'(nf_first_exp), 32'h57b1);
    checkOutput("nf.first_act", 32'(nf_first_act), 32'h57b0);
    idleInputs();

    // Fill the FIFO, then overflow it
    doReset();
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, 16'h0100 + 16'(i), 1'b0, 16'h0, 1'b0);
      if (i == 6) checkOutput("full.ready_at7", 32'(exp_ready), 32'h1);
    end
    checkOutput("full.ready_at8", 32'(exp_ready), 32'h0);
    checkOutput("full.no_fail", 32'(fail), 32'h0);
    applyStimulus(1'b1, 16'h0108, 1'b0, 16'h0, 1'b0);
    checkOutput("ovf.fail", 32'(fail), 32'h1);
    checkOutput("ovf.cause", 32'(fail_cause), 32'h2);
    idleInputs();

    // One push, no results: timeout exactly TMO cycles after the push edge
    doReset();
    applyStimulus(1'b1, 16'h11f5, 1'b0, 16'h0, 1'b0);
    idleInputs();
    for (int k = 1; k <= TMO; k++) begin
      step();
      if (k == TMO - 1) checkOutput("tmo.early", 32'(fail), 32'h0);
    end
    checkOutput("tmo.fail", 32'(fail), 32'h1);
    checkOutput("tmo.cause", 32'(fail_cause), 32'h3);

    // Simultaneous push/pop, then result on empty FIFO alongside a push
    doReset();
    applyStimulus(1'b1, 16'haaaa, 1'b0, 16'h0, 1'b0);
    applyStimulus(1'b1, 16'hbbbb, 1'b1, 16'haaaa, 1'b0);
    applyStimulus(1'b0, 16'h0, 1'b1, 16'hbbbb, 1'b0);
    checkOutput("pp.match", 32'(match_count), 32'h2);
    checkOutput("pp.no_fail", 32'(fail), 32'h0);
    applyStimulus(1'b1, 16'hcccc, 1'b1, 16'hcccc, 1'b0);
    checkOutput("bypass.fail", 32'(fail), 32'h1);
    checkOutput("bypass.cause", 32'(fail_cause), 32'h2);
    idleInputs();

    // Result before any push, then reset with active inputs, then rerun
    doReset();
    applyStimulus(1'b0, 16'h0, 1'b1, 16'h1234, 1'b0);
    checkOutput("early.fail", 32'(fail), 32'h1);
    checkOutput("early.cause", 32'(fail_cause), 32'h2);
    reset     = 1'b1;
    exp_valid = 1'b1;
    exp_data  = 16'hdead;
    act_valid = 1'b1;
    act_data  = 16'hbeef;
    step();
    reset = 1'b0;
    idleInputs();
    checkReset("reset1");
    runPassSequence("rerun");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
